// File: rtl/mdu_iterative.sv
// mdu_iterative: radix-2 iterative multiply/divide unit owning HI/LO.
// Optional MDU_MACC_EN enables MADD/MSUB (op 6/7) multiply-accumulate.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

`ifdef MDU_MACC_EN
  localparam bit MaccEn = 1'b1;
`else
  localparam bit MaccEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2:0]         op_q, op_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic             is_macc, is_mul, is_div, is_sgn;
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    is_macc = MaccEn && (op == OP_MADD || op == OP_MSUB);
    is_mul  = (op == OP_MULT) || (op == OP_MULTU) || is_macc;
    is_div  = (op == OP_DIV) || (op == OP_DIVU);
    is_sgn  = (op == OP_MULT) || (op == OP_DIV) || is_macc;
    sa      = is_sgn & a[WIDTH-1];
    sb      = is_sgn & b[WIDTH-1];
    abs_a   = sa ? -a : a;
    abs_b   = sb ? -b : b;
  end

  logic               run_macc, run_mul;
  logic [WIDTH:0]     msum, rtry, rdiff;
  logic [2*WIDTH-1:0] mul_nx, div_nx, step_nx;
  logic [2*WIDTH-1:0] prod, macc;
  logic [WIDTH-1:0]   quo, rem;

  // Multiply keeps the multiplier in acc low half; divide keeps the
  // partial remainder high and the dividend/quotient low.
  always_comb begin
    run_macc = MaccEn && (op_q == OP_MADD || op_q == OP_MSUB);
    run_mul  = (op_q == OP_MULT) || (op_q == OP_MULTU);
    msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, ma_q} : '0);
    mul_nx   = {msum, acc_q[WIDTH-1:1]};
    rtry     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rdiff    = rtry - {1'b0, mb_q};
    div_nx   = rdiff[WIDTH]
             ? {rtry[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
             : {rdiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    step_nx  = (run_mul || run_macc) ? mul_nx : div_nx;
    prod     = qneg_q ? -mul_nx : mul_nx;
    macc     = (op_q == OP_MSUB) ? {hi_q, lo_q} - prod
                                 : {hi_q, lo_q} + prod;
    quo      = qneg_q ? -div_nx[WIDTH-1:0] : div_nx[WIDTH-1:0];
    rem      = rneg_q ? -div_nx[2*WIDTH-1:WIDTH]
                      : div_nx[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (is_mul || is_div) begin
            state_d = RUN;
            cnt_d   = '0;
            op_d    = op;
            ma_d    = abs_a;
            mb_d    = abs_b;
            qneg_d  = sa ^ sb;
            rneg_d  = sa;
            dz_d    = 1'b0;
            acc_d   = {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
            // Zero divisor: one pass through RUN to reach FIN in cycle 2.
            if (is_div && b == '0) begin
              dz_d  = 1'b1;
              ma_d  = a;
              cnt_d = CNT_W'(WIDTH - 1);
            end
          end else begin
            done_d = 1'b1;
            if (op == OP_MTHI) hi_d = a;
            if (op == OP_MTLO) lo_d = a;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIN;
            done_d  = 1'b1;
            unique case (1'b1)
              dz_q: begin
                hi_d = ma_q;
                lo_d = '1;
              end
              run_macc: {hi_d, lo_d} = macc;
              run_mul:  {hi_d, lo_d} = prod;
              default: begin
                hi_d = rem;
                lo_d = quo;
              end
            endcase
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed + random scoreboard bench for mdu_iterative.
// MADD/MSUB expectations follow MDU_MACC_EN when it is defined.
module tb_mdu_iterative;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

`ifdef MDU_MACC_EN
  localparam bit MACC = 1'b1;
`else
  localparam bit MACC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] cur = '0;
  logic [63:0] sbq[$];

  mdu_iterative #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic [63:0] c);
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0] ux, uy, uq, ur, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    r  = c;
    case (o)
      OP_MULT:  r = sx * sy;
      OP_MULTU: r = ux * uy;
      OP_DIV: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          sq = sx / sy;
          sr = sx % sy;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      OP_DIVU: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uy;
          ur = ux % uy;
          r  = {ur[31:0], uq[31:0]};
        end
      end
      OP_MTHI: r = {x, c[31:0]};
      OP_MTLO: r = {c[63:32], x};
      OP_MADD: r = MACC ? c + sx * sy : c;
      OP_MSUB: r = MACC ? c - sx * sy : c;
      default: r = c;
    endcase
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] ra, input logic [31:0] rb,
                        input int exp_cyc, input logic exp_busy,
                        input int inj_cyc);
    logic [63:0] e, got;
    int ndone, done_cyc, bad;
    e = model(o, ra, rb, cur);
    sbq.push_back(e);
    cur = e;
    ndone = 0;
    done_cyc = -1;
    bad = 0;
    op = o;
    a = ra;
    b = rb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == inj_cyc) begin
        start = 1'b1;
        op = OP_MULT;
        a = 32'd3;
        b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          got = {hi, lo};
          if (sbq.size() > 0) e = sbq.pop_front();
          else e = ~got;
          chk({tag, "_hilo"}, got, e);
        end
      end
      if ((done_cyc < 0 || cyc == done_cyc) && busy !== exp_busy) bad++;
      if (done_cyc > 0 && cyc > done_cyc && busy !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (done_cyc < 0 && sbq.size() > 0) void'(sbq.pop_front());
    chk({tag, "_donecyc"}, 64'(done_cyc), 64'(exp_cyc));
    chk({tag, "_ndone"}, 64'(ndone), 64'd1);
    chk({tag, "_busy"}, 64'(bad), 64'd0);
  endtask

  task automatic run_flush(input string tag, input logic [2:0] o,
                           input logic [31:0] ra, input logic [31:0] rb,
                           input int fcyc);
    int ndone;
    logic bsy_f, bsy_a;
    ndone = 0;
    bsy_f = 1'b0;
    bsy_a = 1'b1;
    op = o;
    a = ra;
    b = rb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      flush = (cyc == fcyc);
      if (done === 1'b1) ndone++;
      if (cyc == fcyc) bsy_f = busy;
      if (cyc == fcyc + 1) bsy_a = busy;
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    chk({tag, "_busy_pre"}, 64'(bsy_f), 64'd1);
    chk({tag, "_busy_post"}, 64'(bsy_a), 64'd0);
    chk({tag, "_ndone"}, 64'(ndone), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, cur);
  endtask

  initial begin
    int nd, nb;
    logic [2:0] ro;
    logic [31:0] rx, ry;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    #22;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 33, 1'b1, 0);
    chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           33, 1'b1, 5);
    chk("multu_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 1'b1, 0);
    chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           33, 1'b1, 0);
    chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 1'b1, 0);
    run_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 2, 1'b1, 0);
    chk("divu_zero_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op("div_zero", OP_DIV, 32'hFFFF_FF00, 32'd0, 2, 1'b1, 0);
    run_op("mtlo", OP_MTLO, 32'h1234, 32'd0, 1, 1'b0, 0);
    chk("mtlo_lo", 64'(lo), 64'h1234);

    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 2 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      run_op("rand", ro, rx, ry, 33, 1'b1, 0);
    end

    op = OP_MTHI;
    a = 32'hDEAD_BEEF;
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    nd = 0;
    nb = 0;
    for (int c = 0; c < 3; c++) begin
      if (done === 1'b1) nd++;
      if (busy !== 1'b0) nb++;
      @(posedge clk);
      #1;
    end
    chk("idle_flush_done", 64'(nd + nb), 64'd0);
    chk("idle_flush_hilo", {hi, lo}, cur);

    run_op("mthi5", OP_MTHI, 32'd5, 32'd0, 1, 1'b0, 0);
    run_op("mtlo6", OP_MTLO, 32'd6, 32'd0, 1, 1'b0, 0);
    run_flush("flush_divu", OP_DIVU, 32'd10, 32'd3, 10);
    chk("flush_const", {hi, lo}, 64'h0000_0005_0000_0006);

    run_op("mthi0", OP_MTHI, 32'd0, 32'd0, 1, 1'b0, 0);
    run_op("mtlo1s", OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1, 1'b0, 0);
    if (MACC) begin
      run_op("madd", OP_MADD, 32'd1, 32'd1, 33, 1'b1, 0);
      chk("madd_const", {hi, lo}, 64'h0000_0001_0000_0000);
      run_op("msub", OP_MSUB, 32'd2, 32'd3, 33, 1'b1, 0);
      chk("msub_const", {hi, lo}, 64'h0000_0000_FFFF_FFFA);
    end else begin
      run_op("madd_nop", OP_MADD, 32'd1, 32'd1, 1, 1'b0, 0);
      run_op("msub_nop", OP_MSUB, 32'd2, 32'd3, 1, 1'b0, 0);
      chk("nop_const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    end

    op = OP_MULT;
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_busy", 64'(busy), 64'd0);
    chk("mid_reset_hilo", {hi, lo}, 64'd0);
    cur = '0;
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      @(posedge clk);
      #1;
    end
    chk("post_reset_quiet", 64'(nd), 64'd0);
    chk("post_reset_hilo", {hi, lo}, cur);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised iterative multiply/divide unit for the pipelined CPU; owns the HI/LO architectural registers.
- Launched from EX by a one-cycle `start` pulse.
- Raises `busy` so hazard logic can stall mfhi/mflo and any further MDU op until `done`.
- Generalises width and adds signed/unsigned modes, divide-by-zero/overflow rules and pipeline flush.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
CNT_W, $clog2(WIDTH)+1, iteration counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  launch op; sampled only when busy=0
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MADD 7=MSUB
a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data)
b  in  WIDTH  rt operand (divisor / multiplier)
flush  in  1  abort in-flight op (branch/exception squash)
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse; hi/lo hold the new result in that cycle
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async): state=IDLE; busy=0; done=0; hi=0; lo=0; counter=0.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1, flush=0, op in 0..3:
  - Latch magnitudes of a and b (absolute values for signed ops), result signs and op.
  - counter=0; go to RUN.
- RUN: one radix-2 iteration per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After WIDTH iterations go to FIN.
- FIN: apply sign fix-up, write hi/lo, assert done for that cycle, return to IDLE.
- Latency: start edge at cycle 0 → busy=1 in cycles 1..WIDTH+1 → done=1 in cycle WIDTH+1 → busy=0 in cycle WIDTH+2.
- Multiply: {hi,lo} = full 2*WIDTH product; signed for MULT, unsigned for MULTU.
- Divide: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (b=0) is detected at start: skip RUN, go straight to FIN.
  - Result hi=a, lo=all ones; done in cycle 2.
- Signed overflow (a=MIN, b=-1): lo=MIN, hi=0; normal latency.
- MTHI/MTLO: write hi (MTHI) or lo (MTLO) on the start edge; never leave IDLE; busy stays 0; done=1 in cycle 1.
- start while busy=1: ignored; no queueing.
- flush=1 while busy: return to IDLE next edge; hi/lo unchanged; no done pulse.
- flush=1 together with start in IDLE: start is ignored.
- Flush has no effect in IDLE and no effect in the FIN cycle itself (the result commits).
- hi/lo change only in FIN or on MTHI/MTLO; otherwise they hold.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.

Optional Feature:
Macro MDU_MACC_EN.
- Defined: op 6 (MADD) and op 7 (MSUB) are signed multiply-accumulate.
  - FIN writes {hi,lo} = {hi,lo} ± product, modulo 2^(2*WIDTH).
  - {hi,lo} is sampled in FIN, so an interleaved MTHI/MTLO cannot occur.
  - Latency is the same as MULT.
- Undefined: op 6/7 are treated as no-op; start does not leave IDLE; busy=0; hi/lo unchanged; done=1 in cycle 1.

Test Plan (WIDTH=32):
1. MULT a=0xFFFFFFFD (-3), b=7 → done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1..33.
2. MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; a second start at cycle 5 is ignored (result unchanged, single done).
3. DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
4. DIVU a=100, b=0 → done at cycle 2, hi=0x00000064, lo=0xFFFFFFFF. Then MTLO a=0x1234 → lo=0x1234 and done at cycle 1, busy never high.
5. From hi=5, lo=6: DIVU a=10, b=3 with flush at cycle 10 → busy=0 at cycle 11, no done, hi=5, lo=6 retained. Async reset at cycle 20 of a MULT → hi=lo=0, busy=0 immediately.
6. With MDU_MACC_EN, from hi=0, lo=0xFFFFFFFF: MADD a=1, b=1 → hi=1, lo=0. MSUB a=2, b=3 → hi=0, lo=0xFFFFFFFA.
